pipeline_if_stage: RTL and testbench

PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

---
 rtl/pipeline_if_stage_pkg.sv | 26 ++
 rtl/pipeline_if_stage_dram_fetch_unit.sv | 36 +++
 rtl/pipeline_if_stage.sv | 122 ++++++++++++
 tb/tb_pipeline_if_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, the bubble
// instruction, the DRAM window base and small decode helpers.
package pipeline_if_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } if_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [63:0] DRAM_BASE_ADDR = 64'h0000_0000_8000_0000;

    // A 64-bit DRAM read carries two instructions; pc[2] picks the upper one.
    function automatic logic [31:0] dram_word_select(input logic word_hi,
                                                     input logic [63:0] rdata);
        return word_hi ? rdata[63:32] : rdata[31:0];
    endfunction

    function automatic logic pc_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/pipeline_if_stage_dram_fetch_unit.sv
// DRAM fetch helper: picks the 32-bit instruction out of the read doubleword
// and runs the wait counter that bounds a pending DRAM fetch.
module if_dram_fetch_unit
    import pipeline_if_stage_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_en,
    input  logic        word_hi,
    input  logic [63:0] dram_rdata,
    output logic [31:0] instr,
    output logic        timeout
);

    localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

    logic [CW-1:0] wait_cnt;

    // Counter only survives while the stage keeps waiting; any other cycle clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (count_en) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (wait_cnt == CNT_MAX);
    assign instr   = dram_word_select(word_hi, dram_rdata);

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: presents ROM or DRAM instructions to IF/ID, waits
// on slow DRAM reads, and handles stall, flush and DRAM timeout.
module pipeline_if_stage #(
    parameter int unsigned DRAM_WAIT_MAX = 15,
    parameter logic [31:0] NOP_INSTR     = pipeline_if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] pc_IFP,
    input  logic        if_channel_sel,
    input  logic [31:0] rom_data,
    input  logic [63:0] dram_rdata,
    input  logic        dram_rvalid,
    output logic [63:0] pc_IF,
    output logic [31:0] instr_IF,
    output logic        valid_IF,
    output logic        stall_req,
    output logic        misaligned_IF,
    output logic        fetch_fault
);

    import pipeline_if_stage_pkg::*;

    // state  | meaning
    // RUN    | normal fetch; ROM or zero-wait DRAM captured every unstalled cycle
    // DWAIT  | DRAM read outstanding for pend_pc, prepare stage held
    // HOLD   | DRAM instruction presented while downstream is stalled
    // DROP   | flushed DRAM read still outstanding; its data is discarded
    if_state_t   state;
    logic [63:0] pend_pc;
    logic [63:0] dram_pc;
    logic [31:0] dram_instr;
    logic        in_wait;
    logic        count_en;
    logic        timeout;

    assign in_wait   = (state == ST_DWAIT) || (state == ST_DROP);
    assign stall_req = in_wait;
    assign count_en  = in_wait && !flush && !dram_rvalid && !timeout;
    assign dram_pc   = (state == ST_RUN) ? pc_IFP : pend_pc;

    if_dram_fetch_unit #(
        .WAIT_MAX (DRAM_WAIT_MAX)
    ) u_dram_fetch (
        .clk        (clk),
        .reset      (reset),
        .count_en   (count_en),
        .word_hi    (dram_pc[2]),
        .dram_rdata (dram_rdata),
        .instr      (dram_instr),
        .timeout    (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_RUN;
            pc_IF         <= '0;
            instr_IF      <= NOP_INSTR;
            valid_IF      <= 1'b0;
            misaligned_IF <= 1'b0;
            fetch_fault   <= 1'b0;
            pend_pc       <= '0;
        end else begin
            fetch_fault <= 1'b0;
            if (flush) begin
                valid_IF <= 1'b0;
                instr_IF <= NOP_INSTR;
                state    <= (state == ST_DWAIT) ? ST_DROP : ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (!stall) begin
                            if (!if_channel_sel) begin
                                pc_IF         <= pc_IFP;
                                instr_IF      <= rom_data;
                                valid_IF      <= 1'b1;
                                misaligned_IF <= pc_misaligned(pc_IFP[1:0]);
                            end else if (dram_rvalid) begin
                                pc_IF         <= pc_IFP;
                                instr_IF      <= dram_instr;
                                valid_IF      <= 1'b1;
                                misaligned_IF <= pc_misaligned(pc_IFP[1:0]);
                            end else begin
                                pend_pc  <= pc_IFP;
                                valid_IF <= 1'b0;
                                state    <= ST_DWAIT;
                            end
                        end
                    end
                    ST_DWAIT: begin
                        if (dram_rvalid) begin
                            pc_IF         <= pend_pc;
                            instr_IF      <= dram_instr;
                            valid_IF      <= 1'b1;
                            misaligned_IF <= pc_misaligned(pend_pc[1:0]);
                            state         <= stall ? ST_HOLD : ST_RUN;
                        end else if (timeout) begin
                            fetch_fault <= 1'b1;
                            valid_IF    <= 1'b0;
                            instr_IF    <= NOP_INSTR;
                            state       <= ST_RUN;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_DROP: begin
                        if (dram_rvalid || timeout) begin
                            state <= ST_RUN;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Self-checking bench for pipeline_if_stage: directed scenarios plus randomized
// ROM/DRAM traffic compared against a transaction-level reference model.
module tb_pipeline_if_stage;

    localparam int          WMAX      = 15;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [63:0] pc_IFP;
    logic        if_channel_sel;
    logic [31:0] rom_data;
    logic [63:0] dram_rdata;
    logic        dram_rvalid;
    logic [63:0] pc_IF;
    logic [31:0] instr_IF;
    logic        valid_IF;
    logic        stall_req;
    logic        misaligned_IF;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    pipeline_if_stage #(
        .DRAM_WAIT_MAX (WMAX),
        .NOP_INSTR     (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .pc_IFP         (pc_IFP),
        .if_channel_sel (if_channel_sel),
        .rom_data       (rom_data),
        .dram_rdata     (dram_rdata),
        .dram_rvalid    (dram_rvalid),
        .pc_IF          (pc_IF),
        .instr_IF       (instr_IF),
        .valid_IF       (valid_IF),
        .stall_req      (stall_req),
        .misaligned_IF  (misaligned_IF),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [31:0] pick_word(input logic [63:0] pc, input logic [63:0] data);
        return (((pc >> 2) % 2) == 1) ? 32'(data >> 32) : 32'(data % 64'h1_0000_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall          = 1'b1;
        flush          = 1'b0;
        if_channel_sel = 1'b0;
        dram_rvalid    = 1'b0;
        pc_IFP         = rand64();
        rom_data       = $urandom;
        dram_rdata     = rand64();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        repeat (2) tick();
        checks++;
        if ({pc_IF, instr_IF, valid_IF, misaligned_IF, fetch_fault, stall_req} !==
            {64'd0, NOP, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: pc=%h instr=%h v=%b mis=%b ff=%b sr=%b, want pc=0 instr=%h others 0",
                     pc_IF, instr_IF, valid_IF, misaligned_IF, fetch_fault, stall_req, NOP);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({valid_IF, instr_IF, stall_req} !== {1'b0, NOP, 1'b0}) begin
            failures++;
            $display("FAIL reset_release: v=%b instr=%h sr=%b, want v=0 instr=%h sr=0",
                     valid_IF, instr_IF, stall_req, NOP);
        end
    endtask

    task automatic test_rom_directed();
        logic [63:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{64'd0, 64'd4, 64'd8};
        ins = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
        for (int i = 0; i < 3; i++) begin
            stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b0;
            pc_IFP = pcs[i]; rom_data = ins[i];
            tick();
            checks++;
            if ({pc_IF, instr_IF, valid_IF, misaligned_IF} !== {pcs[i], ins[i], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL rom_fetch[%0d]: pc=%h instr=%h v=%b mis=%b, want pc=%h instr=%h v=1 mis=0",
                         i, pc_IF, instr_IF, valid_IF, misaligned_IF, pcs[i], ins[i]);
            end
        end
        drive_idle();
    endtask

    // Issue one DRAM fetch whose rvalid arrives k cycles after issue (k=0: same cycle).
    task automatic test_dram(input logic [63:0] pc, input logic [63:0] data,
                             input int k, input bit stall_end);
        logic [31:0] exp_w;
        logic [63:0] next_pc;
        logic [31:0] next_rom;
        bit          captured;
        bit          hold;
        int          nwait;
        exp_w    = pick_word(pc, data);
        captured = (k <= WMAX + 1);
        nwait    = captured ? k : WMAX + 1;
        hold     = captured && (k > 0) && stall_end;

        stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b1; pc_IFP = pc;
        dram_rvalid = (k == 0);
        dram_rdata  = (k == 0) ? data : rand64();
        for (int i = 1; i <= nwait; i++) begin
            tick();
            checks++;
            if (stall_req !== 1'b1 || valid_IF !== 1'b0) begin
                failures++;
                $display("FAIL dram_wait[%0d]: sr=%b v=%b, want sr=1 v=0", i, stall_req, valid_IF);
            end
            pc_IFP         = rand64();
            if_channel_sel = 1'($urandom_range(1));
            dram_rvalid    = (i == k);
            dram_rdata     = (i == k) ? data : rand64();
            stall          = (i == k) ? stall_end : 1'($urandom_range(1));
        end
        tick();
        checks++;
        if (captured) begin
            if ({valid_IF, pc_IF, instr_IF, misaligned_IF, fetch_fault, stall_req} !==
                {1'b1, pc, exp_w, (pc % 4) != 0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL dram_capture k=%0d: v=%b pc=%h instr=%h mis=%b ff=%b sr=%b, want v=1 pc=%h instr=%h ff=0 sr=0",
                         k, valid_IF, pc_IF, instr_IF, misaligned_IF, fetch_fault, stall_req, pc, exp_w);
            end
        end else begin
            if ({valid_IF, instr_IF, fetch_fault, stall_req} !== {1'b0, NOP, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL dram_timeout k=%0d: v=%b instr=%h ff=%b sr=%b, want v=0 instr=%h ff=1 sr=0",
                         k, valid_IF, instr_IF, fetch_fault, stall_req, NOP);
            end
        end

        drive_idle();
        dram_rvalid = 1'($urandom_range(1));
        tick();
        checks++;
        if ({fetch_fault, valid_IF, instr_IF} !== {1'b0, captured, captured ? exp_w : NOP}) begin
            failures++;
            $display("FAIL dram_after k=%0d: ff=%b v=%b instr=%h, want ff=0 v=%b instr=%h",
                     k, fetch_fault, valid_IF, instr_IF, captured, captured ? exp_w : NOP);
        end

        next_pc  = 64'h100 + 64'($urandom_range(63)) * 4;
        next_rom = $urandom;
        stall = 1'b0; if_channel_sel = 1'b0; dram_rvalid = 1'b0;
        pc_IFP = next_pc; rom_data = next_rom;
        tick();
        checks++;
        if (hold) begin
            if ({valid_IF, pc_IF, instr_IF} !== {1'b1, pc, exp_w}) begin
                failures++;
                $display("FAIL hold_release k=%0d: v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         k, valid_IF, pc_IF, instr_IF, pc, exp_w);
            end
        end else begin
            if ({valid_IF, pc_IF, instr_IF} !== {1'b1, next_pc, next_rom}) begin
                failures++;
                $display("FAIL back_to_rom k=%0d: v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         k, valid_IF, pc_IF, instr_IF, next_pc, next_rom);
            end
        end
        drive_idle();
    endtask

    task automatic test_flush_dwait();
        int high_cycles;
        bit saw_fault;
        stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b1; dram_rvalid = 1'b0;
        pc_IFP = DRAM_BASE + 64'd8;
        tick();
        stall = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        checks++;
        if ({valid_IF, instr_IF, stall_req, fetch_fault} !== {1'b0, NOP, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL flush_to_drop: v=%b instr=%h sr=%b ff=%b, want v=0 instr=%h sr=1 ff=0",
                     valid_IF, instr_IF, stall_req, fetch_fault, NOP);
        end
        flush = 1'b0; dram_rvalid = 1'b1; dram_rdata = 64'h1111_2222_3333_4444;
        tick();
        checks++;
        if ({valid_IF, instr_IF, stall_req, fetch_fault} !== {1'b0, NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL drop_discard: v=%b instr=%h sr=%b ff=%b, want v=0 instr=%h sr=0 ff=0",
                     valid_IF, instr_IF, stall_req, fetch_fault, NOP);
        end
        drive_idle();
        tick();
        checks++;
        if (valid_IF !== 1'b0) begin
            failures++;
            $display("FAIL drop_after: v=%b, want 0", valid_IF);
        end

        // Flushed fetch whose data never arrives: DROP must time out silently.
        stall = 1'b0; if_channel_sel = 1'b1; dram_rvalid = 1'b0; pc_IFP = DRAM_BASE;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b1;
        high_cycles = 0;
        saw_fault   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fetch_fault === 1'b1) saw_fault = 1'b1;
            if (stall_req !== 1'b1) break;
            high_cycles++;
            tick();
        end
        checks++;
        if (high_cycles != WMAX + 1 || saw_fault) begin
            failures++;
            $display("FAIL drop_timeout: stall_req high %0d cycles fault=%b, want %0d cycles fault=0",
                     high_cycles, saw_fault, WMAX + 1);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_stall_flush();
        logic [31:0] ins;
        ins = $urandom;
        stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b0; pc_IFP = 64'h10; rom_data = ins;
        tick();
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1; pc_IFP = rand64(); rom_data = $urandom;
            if_channel_sel = 1'($urandom_range(1)); dram_rvalid = 1'($urandom_range(1));
            tick();
            checks++;
            if ({valid_IF, pc_IF, instr_IF} !== {1'b1, 64'h10, ins}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: v=%b pc=%h instr=%h, want v=1 pc=10 instr=%h",
                         i, valid_IF, pc_IF, instr_IF, ins);
            end
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if ({valid_IF, instr_IF, pc_IF} !== {1'b0, NOP, 64'h10}) begin
            failures++;
            $display("FAIL stall_flush: v=%b instr=%h pc=%h, want v=0 instr=%h pc=10",
                     valid_IF, instr_IF, pc_IF, NOP);
        end
        drive_idle();
    endtask

    task automatic test_rom_random(input int n);
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic [63:0] p;
        logic [31:0] r;
        p = rand64(); r = $urandom;
        stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b0; pc_IFP = p; rom_data = r;
        e_pc = p; e_instr = r; e_valid = 1'b1; e_mis = (p % 4) != 0;
        tick();
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({pc_IF, instr_IF, valid_IF, misaligned_IF, stall_req, fetch_fault} !==
                {e_pc, e_instr, e_valid, e_mis, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rom_random[%0d]: pc=%h instr=%h v=%b mis=%b sr=%b ff=%b, want pc=%h instr=%h v=%b mis=%b sr=0 ff=0",
                         i, pc_IF, instr_IF, valid_IF, misaligned_IF, stall_req, fetch_fault,
                         e_pc, e_instr, e_valid, e_mis);
            end
            p = rand64(); r = $urandom;
            pc_IFP = p; rom_data = r;
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(9) == 0);
            dram_rvalid = 1'($urandom_range(1));
            dram_rdata  = rand64();
            if (flush) begin
                e_valid = 1'b0; e_instr = NOP;
            end else if (!stall) begin
                e_pc = p; e_instr = r; e_valid = 1'b1; e_mis = (p % 4) != 0;
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_dram_random(input int n);
        for (int i = 0; i < n; i++) begin
            test_dram({32'd0, $urandom}, rand64(), int'($urandom_range(20)), 1'($urandom_range(1)));
        end
    endtask

    task automatic test_reset_dwait();
        stall = 1'b0; flush = 1'b0; if_channel_sel = 1'b1; dram_rvalid = 1'b0;
        pc_IFP = DRAM_BASE + 64'd4;
        tick();
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if ({pc_IF, instr_IF, valid_IF, misaligned_IF, fetch_fault, stall_req} !==
            {64'd0, NOP, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_dwait: pc=%h instr=%h v=%b mis=%b ff=%b sr=%b, want reset values",
                     pc_IF, instr_IF, valid_IF, misaligned_IF, fetch_fault, stall_req);
        end
        tick();
        reset = 1'b1;
        stall = 1'b1; if_channel_sel = 1'b1; dram_rvalid = 1'b1; dram_rdata = rand64();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_IF, instr_IF, stall_req, fetch_fault} !== {1'b0, NOP, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_late_rvalid[%0d]: v=%b instr=%h sr=%b ff=%b, want v=0 instr=%h sr=0 ff=0",
                         i, valid_IF, instr_IF, stall_req, fetch_fault, NOP);
            end
        end
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rom_directed();
        test_dram(DRAM_BASE + 64'd4, 64'hDEAD_BEEF_1234_5678, 3, 1'b0);
        test_dram(DRAM_BASE, 64'hCAFE_F00D_0BAD_F00D, 0, 1'b0);
        test_dram(DRAM_BASE + 64'd16, rand64(), 20, 1'b0);
        test_dram(DRAM_BASE + 64'd20, rand64(), WMAX + 1, 1'b1);
        test_flush_dwait();
        test_stall_flush();
        test_rom_random(200);
        test_dram_random(16);
        test_reset_dwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
